// File: rtl/wb_merge_pkg.sv
// Shared writeback types: register-file address, data word and the write request record.
package wb_merge_pkg;

  typedef logic        u1;
  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;

  typedef struct packed {
    u1          valid;
    creg_addr_t wa;
    u64         wd;
  } wb_req_t;

  // x0 is hardwired, so a write to it never creates a hazard.
  function automatic logic [31:0] dest_bit(input u1 valid, input creg_addr_t wa);
    return (valid && wa != '0) ? (32'd1 << wa) : 32'd0;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of long-latency write requests; exposes every slot's destination
// and occupancy so the parent can build the pending-destination mask.
module wb_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_data,
  input  logic             pop,
  output wb_req_t          head,
  output logic [CW-1:0]    cnt,
  output creg_addr_t       entry_wa  [DEPTH],
  output logic [DEPTH-1:0] entry_vld
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    head       = mem[rd_ptr];
    head.valid = mem[rd_ptr].valid && (cnt != '0);
  end

  // A slot is live when its distance from the read pointer (mod DEPTH) is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    entry_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr;
      entry_wa[i]  = mem[i].wa;
      entry_vld[i] = mem[i].valid && ({1'b0, off} < cnt);
    end
  end

endmodule

// File: rtl/wb_merge.sv
// Writeback merge: shares the register-file write port between the fixed-latency pipeline
// and a buffered long-latency unit, with anti-starvation stall request and hazard mask.
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pipe_valid,
  input  creg_addr_t                   pipe_wa,
  input  u64                           pipe_wd,
  input  logic                         mdu_valid,
  output logic                         mdu_ready,
  input  creg_addr_t                   mdu_wa,
  input  u64                           mdu_wd,
  output logic                         wvalid,
  output creg_addr_t                   wa,
  output u64                           wd,
  output logic [31:0]                  pending,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
  output logic                         stall_req
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_req_t          head, win, push_data;
  creg_addr_t       entry_wa [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic             mdu_acc, sel_pipe, sel_fifo, sel_byp, push, pop;
  logic             out_mdu;
  logic [SW-1:0]    starve;

  assign mdu_ready = !reset && (fifo_cnt < CW'(DEPTH));
  assign push_data = '{valid: 1'b1, wa: mdu_wa, wd: mdu_wd};

  wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .cnt       (fifo_cnt),
    .entry_wa  (entry_wa),
    .entry_vld (entry_vld)
  );

  // Bypass only when the FIFO is empty so long-latency results keep acceptance order.
  always_comb begin
    mdu_acc  = mdu_valid && mdu_ready;
    sel_pipe = pipe_valid;
    sel_fifo = !pipe_valid && head.valid;
    sel_byp  = !pipe_valid && !head.valid && mdu_acc;
    pop      = sel_fifo;
    push     = mdu_acc && !sel_byp;
    win      = '0;
    if (sel_pipe)      win = '{valid: 1'b1, wa: pipe_wa, wd: pipe_wd};
    else if (sel_fifo) win = head;
    else if (sel_byp)  win = push_data;
  end

  always_comb begin
    pending = dest_bit(out_mdu, wa);
    for (int i = 0; i < DEPTH; i++) pending |= dest_bit(entry_vld[i], entry_wa[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wvalid    <= 1'b0;
      wa        <= '0;
      wd        <= '0;
      out_mdu   <= 1'b0;
      starve    <= '0;
      stall_req <= 1'b0;
    end else begin
      wvalid  <= win.valid && (win.wa != '0);
      out_mdu <= (sel_fifo || sel_byp) && (win.wa != '0);
      if (win.valid) begin
        wa <= win.wa;
        wd <= win.wd;
      end
      stall_req <= 1'b0;
      if (pop || fifo_cnt == '0) begin
        starve <= '0;
      end else if (sel_pipe) begin
        if (starve == SW'(STARVE_LIMIT - 1)) begin
          starve    <= '0;
          stall_req <= 1'b1;
        end else begin
          starve <= starve + 1'b1;
        end
      end
    end
  end

  a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (reset) !(stall_req && pipe_valid));

endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_wb_merge;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_wa;
  logic [63:0] pipe_wd;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_wa;
  logic [63:0] mdu_wd;
  logic        wvalid;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [31:0] pending;
  logic [2:0]  fifo_cnt;
  logic        stall_req;

  int n_checks = 0;
  int n_pass   = 0;

  wb_merge #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_wa    (pipe_wa),
    .pipe_wd    (pipe_wd),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_wa     (mdu_wa),
    .mdu_wd     (mdu_wd),
    .wvalid     (wvalid),
    .wa         (wa),
    .wd         (wd),
    .pending    (pending),
    .fifo_cnt   (fifo_cnt),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the long-latency buffer is a plain queue in acceptance order.
  typedef struct { logic [4:0] wa; logic [63:0] wd; } ent_t;
  ent_t        m_q[$];
  logic        m_wvalid = 1'b0;
  logic [4:0]  m_wa = '0;
  logic [63:0] m_wd = '0;
  logic        m_out = 1'b0;
  int          m_starve = 0;
  logic        m_stall = 1'b0;

  always @(posedge clk) begin : model
    ent_t w;
    bit   has, frm, popped, acc;
    int   pre;
    if (reset) begin
      m_q.delete();
      m_wvalid = 0; m_wa = '0; m_wd = '0; m_out = 0; m_starve = 0; m_stall = 0;
    end else begin
      pre = m_q.size();
      acc = mdu_valid && (pre < DEPTH);
      has = 0; frm = 0; popped = 0;
      w.wa = '0; w.wd = '0;
      if (pipe_valid) begin
        has = 1; w.wa = pipe_wa; w.wd = pipe_wd;
      end else if (pre > 0) begin
        w = m_q.pop_front(); has = 1; frm = 1; popped = 1;
      end else if (acc) begin
        has = 1; frm = 1; w.wa = mdu_wa; w.wd = mdu_wd; acc = 0;
      end
      if (acc) m_q.push_back('{mdu_wa, mdu_wd});
      m_stall = 0;
      if (popped || pre == 0) m_starve = 0;
      else begin
        m_starve++;
        if (m_starve == STARVE_LIMIT) begin m_stall = 1; m_starve = 0; end
      end
      m_wvalid = has && (w.wa != 0);
      m_out    = has && frm && (w.wa != 0);
      if (has) begin m_wa = w.wa; m_wd = w.wd; end
    end
  end

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (m_q[i]) if (m_q[i].wa != 0) p[m_q[i].wa] = 1'b1;
    if (m_out) p[m_wa] = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    pipe_valid = 0; pipe_wa = '0; pipe_wd = '0;
    mdu_valid = 0; mdu_wa = '0; mdu_wd = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    mdu_valid = 1;
    tick(); tick();
    n_checks++; if (wvalid !== 1'b0) $display("FAIL reset_wvalid got %0d exp 0", wvalid); else n_pass++;
    n_checks++; if (wa !== 5'd0) $display("FAIL reset_wa got %0d exp 0", wa); else n_pass++;
    n_checks++; if (wd !== 64'd0) $display("FAIL reset_wd got %h exp 0", wd); else n_pass++;
    n_checks++; if (fifo_cnt !== 3'd0) $display("FAIL reset_cnt got %0d exp 0", fifo_cnt); else n_pass++;
    n_checks++; if (pending !== 32'd0) $display("FAIL reset_pending got %h exp 0", pending); else n_pass++;
    n_checks++; if (stall_req !== 1'b0) $display("FAIL reset_stall got %0d exp 0", stall_req); else n_pass++;
    n_checks++; if (mdu_ready !== 1'b0) $display("FAIL reset_ready got %0d exp 0", mdu_ready); else n_pass++;
    mdu_valid = 0;
    reset = 0;
    #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL post_reset_ready got %0d exp 1", mdu_ready); else n_pass++;
    tick();
  endtask

  task automatic test_pipe();
    idle();
    pipe_valid = 1; pipe_wa = 5'd5; pipe_wd = 64'hAA;
    tick();
    idle();
    n_checks++; if (wvalid !== 1'b1) $display("FAIL pipe_wvalid got %0d exp 1", wvalid); else n_pass++;
    n_checks++; if (wa !== 5'd5) $display("FAIL pipe_wa got %0d exp 5", wa); else n_pass++;
    n_checks++; if (wd !== 64'hAA) $display("FAIL pipe_wd got %h exp aa", wd); else n_pass++;
    tick();
    n_checks++; if (wvalid !== 1'b0) $display("FAIL pipe_idle_wvalid got %0d exp 0", wvalid); else n_pass++;
  endtask

  task automatic test_bypass();
    idle();
    mdu_valid = 1; mdu_wa = 5'd7; mdu_wd = 64'h11;
    #1;
    n_checks++; if (mdu_ready !== 1'b1) $display("FAIL byp_ready got %0d exp 1", mdu_ready); else n_pass++;
    tick();
    idle();
    n_checks++; if (wvalid !== 1'b1 || wa !== 5'd7 || wd !== 64'h11)
      $display("FAIL byp_write got v=%0d wa=%0d wd=%h exp v=1 wa=7 wd=11", wvalid, wa, wd); else n_pass++;
    n_checks++; if (fifo_cnt !== 3'd0) $display("FAIL byp_cnt got %0d exp 0", fifo_cnt); else n_pass++;
    n_checks++; if (pending !== 32'h80) $display("FAIL byp_pending got %h exp 00000080", pending); else n_pass++;
    tick();
    n_checks++; if (pending !== 32'h0) $display("FAIL byp_pending_clr got %h exp 0", pending); else n_pass++;
  endtask

  task automatic test_same_cycle();
    idle();
    pipe_valid = 1; pipe_wa = 5'd3; pipe_wd = 64'h33;
    mdu_valid = 1; mdu_wa = 5'd4; mdu_wd = 64'h44;
    tick();
    idle();
    n_checks++; if (wvalid !== 1'b1 || wa !== 5'd3) $display("FAIL same_first got v=%0d wa=%0d exp v=1 wa=3", wvalid, wa); else n_pass++;
    n_checks++; if (fifo_cnt !== 3'd1) $display("FAIL same_cnt got %0d exp 1", fifo_cnt); else n_pass++;
    n_checks++; if (pending !== 32'h10) $display("FAIL same_pend1 got %h exp 00000010", pending); else n_pass++;
    tick();
    n_checks++; if (wvalid !== 1'b1 || wa !== 5'd4 || wd !== 64'h44)
      $display("FAIL same_second got v=%0d wa=%0d wd=%h exp v=1 wa=4 wd=44", wvalid, wa, wd); else n_pass++;
    n_checks++; if (pending !== 32'h10) $display("FAIL same_pend2 got %h exp 00000010", pending); else n_pass++;
    tick();
    n_checks++; if (pending !== 32'h0) $display("FAIL same_pend3 got %h exp 0", pending); else n_pass++;
  endtask

  task automatic test_fill();
    logic [4:0] got [5];
    int n = 0;
    bit acc;
    idle();
    pipe_valid = 1; pipe_wa = 5'd20; pipe_wd = 64'h2020;
    for (int i = 0; i < 4; i++) begin
      mdu_valid = 1; mdu_wa = 5'(8 + i); mdu_wd = 64'(256 + i);
      tick();
    end
    mdu_wa = 5'd12; mdu_wd = 64'h10C;
    #1;
    n_checks++; if (fifo_cnt !== 3'd4) $display("FAIL fill_cnt got %0d exp 4", fifo_cnt); else n_pass++;
    n_checks++; if (mdu_ready !== 1'b0) $display("FAIL fill_ready got %0d exp 0", mdu_ready); else n_pass++;
    n_checks++; if (pending !== 32'h0F00) $display("FAIL fill_pending got %h exp 00000f00", pending); else n_pass++;
    tick();
    n_checks++; if (fifo_cnt !== 3'd4 || wa !== 5'd20) $display("FAIL fill_held got cnt=%0d wa=%0d exp cnt=4 wa=20", fifo_cnt, wa); else n_pass++;
    pipe_valid = 0;
    for (int i = 0; i < 5; i++) got[i] = '0;
    for (int c = 0; c < 12 && n < 5; c++) begin
      acc = mdu_valid && mdu_ready;
      tick();
      if (acc) mdu_valid = 0;
      if (wvalid) begin got[n] = wa; n++; end
    end
    n_checks++; if (n != 5) $display("FAIL fill_drain_count got %0d exp 5", n); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (got[i] !== 5'(8 + i)) $display("FAIL fill_order[%0d] got %0d exp %0d", i, got[i], 8 + i); else n_pass++;
    end
    idle();
    tick();
  endtask

  task automatic test_starve();
    idle();
    pipe_valid = 1; pipe_wa = 5'd2; pipe_wd = 64'h22;
    mdu_valid = 1; mdu_wa = 5'd9; mdu_wd = 64'h99;
    tick();
    mdu_valid = 0;
    n_checks++; if (fifo_cnt !== 3'd1) $display("FAIL starve_cnt got %0d exp 1", fifo_cnt); else n_pass++;
    for (int i = 1; i <= STARVE_LIMIT; i++) begin
      tick();
      n_checks++; if (stall_req !== (i == STARVE_LIMIT)) $display("FAIL starve_stall[%0d] got %0d exp %0d", i, stall_req, i == STARVE_LIMIT); else n_pass++;
    end
    pipe_valid = 0;
    tick();
    n_checks++; if (wvalid !== 1'b1 || wa !== 5'd9 || wd !== 64'h99)
      $display("FAIL starve_pop got v=%0d wa=%0d wd=%h exp v=1 wa=9 wd=99", wvalid, wa, wd); else n_pass++;
    n_checks++; if (stall_req !== 1'b0 || fifo_cnt !== 3'd0)
      $display("FAIL starve_after got stall=%0d cnt=%0d exp stall=0 cnt=0", stall_req, fifo_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_zero_and_reset();
    idle();
    mdu_valid = 1; mdu_wa = 5'd0; mdu_wd = 64'h55;
    tick();
    mdu_valid = 0;
    n_checks++; if (wvalid !== 1'b0 || pending !== 32'h0)
      $display("FAIL zero_write got v=%0d pending=%h exp v=0 pending=0", wvalid, pending); else n_pass++;
    pipe_valid = 1; pipe_wa = 5'd1; pipe_wd = 64'h1;
    for (int i = 0; i < 3; i++) begin
      mdu_valid = 1; mdu_wa = 5'(13 + i); mdu_wd = 64'(i);
      tick();
    end
    idle();
    n_checks++; if (fifo_cnt !== 3'd3 || pending !== 32'hE000)
      $display("FAIL prereset got cnt=%0d pending=%h exp cnt=3 pending=0000e000", fifo_cnt, pending); else n_pass++;
    reset = 1;
    tick();
    reset = 0;
    n_checks++; if (fifo_cnt !== 3'd0 || wvalid !== 1'b0 || pending !== 32'h0)
      $display("FAIL midreset got cnt=%0d v=%0d pending=%h exp 0 0 0", fifo_cnt, wvalid, pending); else n_pass++;
    tick();
    n_checks++; if (wvalid !== 1'b0 || fifo_cnt !== 3'd0)
      $display("FAIL postreset got v=%0d cnt=%0d exp v=0 cnt=0", wvalid, fifo_cnt); else n_pass++;
  endtask

  task automatic test_random(input int ncyc);
    bit last_acc = 1;
    bit exp_ready;
    idle();
    for (int c = 0; c < ncyc; c++) begin
      reset      = ($urandom_range(0, 99) == 0);
      pipe_valid = !m_stall && ($urandom_range(0, 3) != 0);
      pipe_wa    = 5'($urandom_range(0, 31));
      pipe_wd    = {$urandom, $urandom};
      if (!mdu_valid || last_acc) begin
        mdu_valid = $urandom_range(0, 1);
        mdu_wa    = 5'($urandom_range(0, 15));
        mdu_wd    = {$urandom, $urandom};
      end
      exp_ready = !reset && (m_q.size() < DEPTH);
      #1;
      n_checks++; if (mdu_ready !== exp_ready) $display("FAIL rnd_ready c=%0d got %0d exp %0d", c, mdu_ready, exp_ready); else n_pass++;
      last_acc = mdu_valid && exp_ready;
      tick();
      n_checks++; if (wvalid !== m_wvalid) $display("FAIL rnd_wvalid c=%0d got %0d exp %0d", c, wvalid, m_wvalid); else n_pass++;
      if (m_wvalid) begin
        n_checks++; if (wa !== m_wa || wd !== m_wd)
          $display("FAIL rnd_write c=%0d got wa=%0d wd=%h exp wa=%0d wd=%h", c, wa, wd, m_wa, m_wd); else n_pass++;
      end
      n_checks++; if (fifo_cnt !== 3'(m_q.size())) $display("FAIL rnd_cnt c=%0d got %0d exp %0d", c, fifo_cnt, m_q.size()); else n_pass++;
      n_checks++; if (pending !== model_pending()) $display("FAIL rnd_pending c=%0d got %h exp %h", c, pending, model_pending()); else n_pass++;
      n_checks++; if (stall_req !== m_stall) $display("FAIL rnd_stall c=%0d got %0d exp %0d", c, stall_req, m_stall); else n_pass++;
    end
    reset = 0;
    idle();
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_pipe();
    test_bypass();
    test_same_cycle();
    test_fill();
    test_starve();
    test_zero_and_reset();
    test_random(1500);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
